// File: rtl/leaf_pkg.sv
// Shared BFT packet layout for the leaf shell: field widths, bit offsets and a packing helper.
// Packets are {valid, dest_leaf, dest_port, addr, payload}, MSB first.
package leaf_pkg;

  localparam int PKT_PAYLOAD_BITS  = 32;
  localparam int PKT_LEAF_BITS     = 5;
  localparam int PKT_PORT_BITS     = 4;
  localparam int PKT_ADDR_BITS     = 7;
  localparam int PKT_PACKET_BITS   = 1 + PKT_LEAF_BITS + PKT_PORT_BITS + PKT_ADDR_BITS + PKT_PAYLOAD_BITS;

  localparam int PKT_PAYLOAD_LSB   = 0;
  localparam int PKT_ADDR_LSB      = PKT_PAYLOAD_LSB + PKT_PAYLOAD_BITS;
  localparam int PKT_PORT_LSB      = PKT_ADDR_LSB + PKT_ADDR_BITS;
  localparam int PKT_LEAF_LSB      = PKT_PORT_LSB + PKT_PORT_BITS;
  localparam int PKT_VALID_BIT     = PKT_LEAF_LSB + PKT_LEAF_BITS;

  function automatic logic [PKT_PACKET_BITS-1:0] pack_packet(
    input logic [PKT_LEAF_BITS-1:0]    dest_leaf,
    input logic [PKT_PORT_BITS-1:0]    dest_port,
    input logic [PKT_ADDR_BITS-1:0]    addr,
    input logic [PKT_PAYLOAD_BITS-1:0] payload
  );
    return {1'b1, dest_leaf, dest_port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_out_fifo.sv
// Per-port synchronous FIFO with registered empty and ready (registered not-full) flags.
// Read data is the head word, visible combinationally so a pop can feed the packet register directly.
module leaf_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                empty_q, ready_q;

  always_comb begin
    count_d = count_q + {{PTR_BITS{1'b0}}, wr_en_i} - {{PTR_BITS{1'b0}}, rd_en_i};
  end

  // ready resets low so the user sees no ack until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      ready_q <= (count_d != (PTR_BITS+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign ready_o   = ready_q;

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output stage: per-port FIFOs round-robin merged into one BFT packet stream,
// with per-port destination config, destination credit tracking and BRAM address counters.
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS           = PKT_PACKET_BITS,
  parameter int PAYLOAD_BITS          = PKT_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS         = PKT_LEAF_BITS,
  parameter int NUM_PORT_BITS         = PKT_PORT_BITS,
  parameter int NUM_ADDR_BITS         = PKT_ADDR_BITS,
  parameter int NUM_OUT_PORTS         = 5,
  parameter int FIFO_DEPTH            = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              upd_port,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  localparam int MAX_CREDIT = 1 << NUM_ADDR_BITS;
  localparam int IDX_SPAN   = 1 << NUM_PORT_BITS;

  logic [NUM_OUT_PORTS-1:0] fifo_empty, eligible, pop;
  logic [PAYLOAD_BITS-1:0]  fifo_data [NUM_OUT_PORTS];
  logic [IDX_SPAN-1:0]      eligible_ext;

  logic [NUM_OUT_PORTS-1:0] configured_q;
  logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS:0]   credit_q    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS:0]   credit_d    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q      [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] last_grant_q, grant_idx;
  logic [NUM_PORT_BITS:0]   grant_sum;
  logic                     grant_vld;
  logic [PACKET_BITS-1:0]   packet_d, dout_q;
  int                       credit_sum;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    leaf_out_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .wr_en_i   (vld_user2interface[gi] & ack_interface2user[gi]),
      .wr_data_i (din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_en_i   (pop[gi]),
      .rd_data_o (fifo_data[gi]),
      .empty_o   (fifo_empty[gi]),
      .ready_o   (ack_interface2user[gi])
    );

    assign eligible[gi] = !fifo_empty[gi] && configured_q[gi] && (credit_q[gi] != '0);
    assign pop[gi]      = grant_vld && (grant_idx == NUM_PORT_BITS'(gi));
  end

  assign eligible_ext = IDX_SPAN'(eligible);

  // Scan ports last_grant+1 .. last_grant+N (mod N); the first eligible one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_sum = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      grant_sum = {1'b0, last_grant_q} + (NUM_PORT_BITS+1)'(k);
      if (grant_sum >= (NUM_PORT_BITS+1)'(NUM_OUT_PORTS))
        grant_sum = grant_sum - (NUM_PORT_BITS+1)'(NUM_OUT_PORTS);
      if (!grant_vld && !resend && eligible_ext[grant_sum[NUM_PORT_BITS-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = grant_sum[NUM_PORT_BITS-1:0];
      end
    end
  end

  always_comb begin
    packet_d = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (pop[i])
        packet_d = {1'b1, dest_leaf_q[i], dest_port_q[i], addr_q[i], fifo_data[i]};
    end
  end

  // A send and a credit return on the same port net out before saturating.
  always_comb begin
    credit_sum = 0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum = int'(credit_q[i]) - (pop[i] ? 1 : 0)
                 + ((upd_vld && upd_port == NUM_PORT_BITS'(i)) ? FREESPACE_UPDATE_SIZE : 0);
      if (credit_sum > MAX_CREDIT) credit_sum = MAX_CREDIT;
      credit_d[i] = (NUM_ADDR_BITS+1)'(credit_sum);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        configured_q[i] <= 1'b0;
        dest_leaf_q[i]  <= '0;
        dest_port_q[i]  <= '0;
        credit_q[i]     <= (NUM_ADDR_BITS+1)'(MAX_CREDIT);
        addr_q[i]       <= '0;
      end
      last_grant_q <= NUM_PORT_BITS'(NUM_OUT_PORTS - 1);
      dout_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
          configured_q[i] <= 1'b1;
          dest_leaf_q[i]  <= cfg_dest_leaf;
          dest_port_q[i]  <= cfg_dest_port;
        end
        credit_q[i] <= credit_d[i];
        if (pop[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
      end
      if (grant_vld) last_grant_q <= grant_idx;
      dout_q <= packet_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomised and directed bench for leaf_out_arbiter against a queue-based behavioural model.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
module tb_leaf_out_arbiter;

  localparam int NP    = 5;
  localparam int PB    = 32;
  localparam int DEPTH = 4;
  localparam int PKT   = 49;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NP*PB-1:0] din;
  logic [NP-1:0]   vld, ack;
  logic            cfg_we, upd_vld, resend;
  logic [3:0]      cfg_port, cfg_dest_port, upd_port;
  logic [4:0]      cfg_dest_leaf;
  logic [PKT-1:0]  dout;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dest_leaf           (cfg_dest_leaf),
    .cfg_dest_port           (cfg_dest_port),
    .upd_vld                 (upd_vld),
    .upd_port                (upd_port),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_cnt  = 0;

  // behavioural model state
  logic [31:0]    mq [NP][$];
  bit             m_cfg    [NP];
  logic [4:0]     m_leaf   [NP];
  logic [3:0]     m_port   [NP];
  int             m_credit [NP];
  int             m_addr   [NP];
  int             m_last;
  logic [NP-1:0]  m_ack;
  logic [PKT-1:0] exp_dout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      m_cfg[i]    = 1'b0;
      m_leaf[i]   = '0;
      m_port[i]   = '0;
      m_credit[i] = 128;
      m_addr[i]   = 0;
    end
    m_last   = NP - 1;
    m_ack    = '0;
    exp_dout = '0;
  endtask

  task automatic model_step();
    bit          found;
    int          g;
    int          p;
    logic [31:0] w;
    found    = 1'b0;
    g        = 0;
    exp_dout = '0;
    if (!resend) begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (!found && mq[p].size() > 0 && m_cfg[p] && m_credit[p] > 0) begin
          found = 1'b1;
          g     = p;
        end
      end
    end
    if (found) begin
      w        = mq[g].pop_front();
      exp_dout = {1'b1, m_leaf[g], m_port[g], 7'(m_addr[g]), w};
      m_credit[g] = m_credit[g] - 1;
      m_addr[g]   = (m_addr[g] + 1) % 128;
      m_last      = g;
      $display("pkt src=%0d leaf=%0d port=%0d addr=%0d data=%h credit=%0d",
               g, m_leaf[g], m_port[g], exp_dout[38:32], w, m_credit[g]);
    end
    if (cfg_we && int'(cfg_port) < NP) begin
      m_cfg[cfg_port]  = 1'b1;
      m_leaf[cfg_port] = cfg_dest_leaf;
      m_port[cfg_port] = cfg_dest_port;
    end
    if (upd_vld && int'(upd_port) < NP) begin
      m_credit[upd_port] = m_credit[upd_port] + 64;
      if (m_credit[upd_port] > 128) m_credit[upd_port] = 128;
    end
    for (int i = 0; i < NP; i++)
      if (vld[i] && m_ack[i]) mq[i].push_back(din[i*PB +: PB]);
    for (int i = 0; i < NP; i++)
      m_ack[i] = (mq[i].size() != DEPTH);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("dout", dout, exp_dout);
    chk("ack", ack, m_ack);
    if (dout[PKT-1]) obs_cnt++;
  endtask

  task automatic idle();
    vld = '0; cfg_we = 1'b0; upd_vld = 1'b0; resend = 1'b0;
    cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0; upd_port = '0;
    for (int i = 0; i < NP; i++) din[i*PB +: PB] = $urandom;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_dout", dout, '0);
    chk("rst_ack", ack, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle();
  endtask

  task automatic configure(input int port, input int leaf, input int dport);
    idle();
    cfg_we = 1'b1; cfg_port = 4'(port); cfg_dest_leaf = 5'(leaf); cfg_dest_port = 4'(dport);
    cycle();
    idle();
  endtask

  logic [PKT-1:0] first_pkt;
  int             rs_left;
  bit             upd_done;

  initial begin
    idle();
    @(negedge clk);

    // first packet and address increment
    do_reset();
    configure(0, 3, 2);
    vld[0] = 1'b1; din[0 +: PB] = 32'hDEADBEEF;
    cycle();
    idle();
    cycle();
    first_pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
    chk("first_pkt", dout, first_pkt);
    vld[0] = 1'b1;
    cycle();
    idle();
    cycle();
    chk("second_addr", dout[38:32], 7'd1);

    // credit drain on port 1; top-up lands together with the send at credit 1
    do_reset();
    configure(1, 7, 9);
    obs_cnt  = 0;
    upd_done = 1'b0;
    for (int c = 0; c < 230; c++) begin
      idle();
      vld = 5'b00010;
      if (!upd_done && m_credit[1] == 1 && mq[1].size() > 0) begin
        upd_vld = 1'b1; upd_port = 4'd1; upd_done = 1'b1;
      end
      cycle();
    end
    chk("drain_total", obs_cnt, 192);
    chk("drain_ack_low", ack[1], 1'b0);

    // repeated updates saturate at 128
    for (int c = 0; c < 4; c++) begin idle(); upd_vld = 1'b1; upd_port = 4'd1; cycle(); end
    for (int c = 0; c < 10; c++) begin idle(); cycle(); end
    for (int c = 0; c < 3; c++) begin idle(); upd_vld = 1'b1; upd_port = 4'd1; cycle(); end
    obs_cnt = 0;
    for (int c = 0; c < 150; c++) begin idle(); vld = 5'b00010; cycle(); end
    chk("sat_total", obs_cnt, 128);

    // all ports busy, round robin, with a 3-cycle resend burst
    do_reset();
    for (int i = 0; i < NP; i++) configure(i, i + 10, i);
    obs_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      idle();
      vld = '1;
      resend = (c >= 30 && c < 33);
      cycle();
    end
    chk("rr_total", obs_cnt, 56);

    // unconfigured port holds its data until configured
    do_reset();
    vld[3] = 1'b1;
    cycle();
    idle();
    for (int c = 0; c < 5; c++) cycle();
    configure(3, 21, 5);
    cycle();
    chk("late_cfg", dout[PKT-1], 1'b1);

    // random traffic with an asynchronous reset in the middle
    do_reset();
    configure(0, 1, 1);
    configure(2, 2, 2);
    configure(4, 4, 4);
    rs_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        idle();
        @(negedge clk);
        do_reset();
        configure(1, 30, 15);
        configure(3, 31, 14);
      end
      idle();
      for (int i = 0; i < NP; i++) vld[i] = ($urandom_range(0, 9) < 7);
      cfg_we        = ($urandom_range(0, 49) == 0);
      cfg_port      = 4'($urandom_range(0, 7));
      cfg_dest_leaf = 5'($urandom_range(0, 31));
      cfg_dest_port = 4'($urandom_range(0, 15));
      upd_vld       = ($urandom_range(0, 29) == 0);
      upd_port      = 4'($urandom_range(0, 7));
      if (rs_left > 0) begin
        resend = 1'b1; rs_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        resend = 1'b1; rs_left = $urandom_range(0, 2);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Parametrised output stage for a leaf shell: accepts data from NUM_OUT_PORTS user output streams (valid/ack), buffers each in a small per-port FIFO, and round-robin merges them into a single BFT packet stream. Destination leaf and port come from per-port config registers, and a per-port credit counter tracks free BRAM space at the destination. It sits between the user kernel outputs and the BFT-facing output of the leaf interface, replacing a fixed-port-count output path.

## Interface
- PACKET_BITS, 49, BFT packet width; equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, destination BRAM address width; initial credit = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 5, number of user output streams (1..2^NUM_PORT_BITS)
- FIFO_DEPTH, 4, per-port FIFO depth, power of 2, ≥2
- FREESPACE_UPDATE_SIZE, 64, credits returned per update
---
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i at slice i
- vld_user2interface  in  NUM_OUT_PORTS  user word valid
- ack_interface2user  out  NUM_OUT_PORTS  ready; transfer when vld&ack
- cfg_we  in  1  write destination for cfg_port
- cfg_port  in  NUM_PORT_BITS  local output port being configured
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dest_port  in  NUM_PORT_BITS  destination port
- upd_vld  in  1  freespace update
- upd_port  in  NUM_PORT_BITS  local output port receiving credit
- resend  in  1  stall: hold all state, drive zero packet
- dout_leaf_interface2bft  out  PACKET_BITS  {valid, dest_leaf, dest_port, addr, payload}, MSB first

## Operation
- Per port: FIFO, configured bit, dest_leaf/dest_port regs, credit counter (NUM_ADDR_BITS+1 bits), addr counter (NUM_ADDR_BITS bits).
- ack[i] = registered ~full[i]. Word accepted on vld[i]&ack[i] is written into FIFO i.
- Eligible port: FIFO non-empty, configured, credit>0.
- Each non-resend cycle: grant the first eligible port strictly after last_grant (wrap at NUM_OUT_PORTS-1 → 0); pop one word, register packet {1, dest_leaf, dest_port, addr, word}, credit−1, addr+1 (wraps 2^NUM_ADDR_BITS−1 → 0), last_grant ← granted port.
- No eligible port: dout = 0; last_grant unchanged.
- resend=1: dout = 0, no pop, no grant, counters unchanged; FIFO writes and credit updates still proceed.
- cfg_we: write dest regs, set configured; cfg_port ≥ NUM_OUT_PORTS ignored. Same-cycle config and grant on the same port: grant uses old values.
- upd_vld: credit[upd_port] += FREESPACE_UPDATE_SIZE, saturating at 2^NUM_ADDR_BITS. Same-cycle update and send on the same port: net +SIZE−1, then saturate. Out-of-range upd_port ignored.
- FIFO full and pop in the same cycle: ack stays 0 this cycle and rises next cycle.

## Timing
- Reset (async assert): dout = 0, ack = 0, FIFOs empty, configured = 0, credit = 2^NUM_ADDR_BITS, addr = 0, last_grant = NUM_OUT_PORTS−1 (port 0 first).
- First cycle after deassert: ack = all 1s.
- Latency: word accepted at edge t appears on dout after edge t+1, given eligibility and no contention.
- Throughput: one packet per cycle aggregate; per port limited by credit.
- Reset mid-operation: buffered words are discarded and no partial packet is emitted.

## Structure
- Package leaf_pkg: packet field offset/width localparams and a pack function; shared with leaf_interface.
- Sub-module leaf_out_fifo: synchronous FIFO with registered full/empty and FIFO_DEPTH parameter, one instance per port via generate.
- Arbiter, credit, and addr logic live in the top module.

## Test plan
- Reset, configure port 0 → leaf 3, port 2; send 0xDEADBEEF → next-edge dout = {1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}; second word uses addr 1.
- Configure all 5 ports and hold every vld high → grants cycle 0,1,2,3,4,0…, one packet per cycle.
- Send 128 words on port 1 with no update → exactly 128 packets, then port 1 stalls and its ack drops after FIFO_DEPTH more words. One upd_vld → 64 more packets, and addr wraps 127 → 0.
- At credit 0, assert upd_vld in the same cycle as a send at credit 1 → credit goes to 64 with no loss; saturation holds at 128.
- Assert resend for 3 cycles mid-stream → dout = 0 for those cycles, then the sequence resumes with no skipped or duplicated addr.
- Unconfigured port with data present → never granted; cfg_we → data emitted on the following cycle.
